// File: rtl/map_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational map_lut wall lookup among NUM_REQ requesters.
// Optional macro MAP_ARB_BOUNDS_CHECK_EN forces wall_out=1 for coordinates outside MAP_W x MAP_H.
module map_lookup_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int MAP_W   = 27,
    parameter int MAP_H   = 24
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   x_in,
    input  logic [7*NUM_REQ-1:0]   y_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   wall_out,
    output logic                   busy,
    output logic [7:0]             map_x,
    output logic [6:0]             map_y,
    input  logic                   map_q,
    output logic [1:0]             dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = PTR_W + 1;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] LOOKUP  = 2'b01;
    localparam logic [1:0] RESPOND = 2'b10;

    localparam logic [8:0] MAP_W_L = 9'(MAP_W);
    localparam logic [7:0] MAP_H_L = 8'(MAP_H);

`ifdef MAP_ARB_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    // Handshake: a requester holds req (and its coordinates until granted); the
    // arbiter answers with a one-cycle ack while wall_out is valid. The requester
    // must drop req on the edge that samples ack high, or it is seen as a new request.

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               wall_q, wall_d;
    logic [7:0]         map_x_q, map_x_d;
    logic [6:0]         map_y_q, map_y_d;

    logic               rr_found;
    logic [PTR_W-1:0]   rr_idx;
    logic [CW-1:0]      cand;
    logic [NUM_REQ-1:0] rr_onehot;
    logic [7:0]         sel_x;
    logic [6:0]         sel_y;
    logic               out_of_bounds;

    // Search upward from ptr with an explicit wrap so non-power-of-2 counts work.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = ptr_q;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!rr_found && req[cand[PTR_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        rr_onehot = '0;
        sel_x     = '0;
        sel_y     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_idx == PTR_W'(i)) begin
                rr_onehot[i] = 1'b1;
                sel_x        = x_in[8*i +: 8];
                sel_y        = y_in[7*i +: 7];
            end
        end
    end

    assign out_of_bounds = ({1'b0, map_x_q} >= MAP_W_L) || ({1'b0, map_y_q} >= MAP_H_L);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        wall_d  = wall_q;
        map_x_d = map_x_q;
        map_y_d = map_y_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    gnt_d   = rr_onehot;
                    win_d   = rr_idx;
                    map_x_d = sel_x;
                    map_y_d = sel_y;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                wall_d  = map_q | (BOUNDS_EN & out_of_bounds);
                ack_d   = gnt_q;
                ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d = RESPOND;
            end
            RESPOND: begin
                gnt_d   = '0;
                ack_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                ack_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            wall_q  <= 1'b0;
            map_x_q <= '0;
            map_y_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            wall_q  <= wall_d;
            map_x_q <= map_x_d;
            map_y_q <= map_y_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign wall_out  = wall_q;
    assign map_x     = map_x_q;
    assign map_y     = map_y_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_map_lookup_arbiter.sv
// Self-checking bench for map_lookup_arbiter: transaction-level round-robin model feeding
// an expected queue, a negedge monitor comparing acks/grants, directed cases then random traffic.
module tb_map_lookup_arbiter;
  localparam int N = 3;
  localparam int W = N + 16;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] x_in = '0;
  logic [7*N-1:0] y_in = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           wall_out;
  logic           busy;
  logic [7:0]     map_x;
  logic [6:0]     map_y;
  logic           map_q;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  map_lookup_arbiter #(.NUM_REQ(N), .MAP_W(27), .MAP_H(24)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .x_in(x_in), .y_in(y_in),
    .gnt(gnt), .ack(ack), .wall_out(wall_out), .busy(busy),
    .map_x(map_x), .map_y(map_y), .map_q(map_q), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // map_lut stand-in and expected wall value
  function automatic logic wall_fn(input int x, input int y);
    return ((x * 7 + y * 3) % 5) == 0;
  endfunction

  function automatic logic exp_wall(input int x, input int y);
`ifdef MAP_ARB_BOUNDS_CHECK_EN
    if (x >= 27 || y >= 24) return 1'b1;
`endif
    return wall_fn(x, y);
  endfunction

  assign map_q = wall_fn(int'(map_x), int'(map_y));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // reference model: a grant may start once the previous lookup has had 3 cycles
  logic [W-1:0] exp_q[$];
  int m_ptr = 0;
  int cyc = 0;
  int free_at = 0;
  logic [N-1:0] m_gnt = '0;

  always @(posedge clock) begin
    int w;
    int xv;
    int yv;
    logic [N-1:0] oh;
    cyc++;
    if (!reset_n) begin
      exp_q.delete();
      m_ptr = 0;
      free_at = cyc + 1;
      m_gnt = '0;
    end else if (cyc >= free_at && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && req[c]) w = c;
      end
      xv = int'(x_in[8*w +: 8]);
      yv = int'(y_in[7*w +: 7]);
      oh = '0;
      oh[w] = 1'b1;
      m_gnt = oh;
      exp_q.push_back({oh, 8'(xv), 7'(yv), exp_wall(xv, yv)});
      m_ptr = (w + 1) % N;
      free_at = cyc + 3;
    end
  end

  // scoreboard monitor
  int got_order[$];

  always @(negedge clock) begin
    logic [W-1:0] e;
    logic m_busy;
    if (reset_n) begin
      m_busy = (cyc + 1 < free_at);
      check("busy", 32'(busy), 32'(m_busy));
      check("gnt", 32'(gnt), 32'(m_busy ? m_gnt : '0));
      if (ack != '0) begin
        for (int i = 0; i < N; i++) if (ack[i]) got_order.push_back(i);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("ack", 32'(ack), 32'(e[W-1:16]));
          check("wall_out", 32'(wall_out), 32'(e[0]));
          check("map_x", 32'(map_x), 32'(e[15:8]));
          check("map_y", 32'(map_y), 32'(e[7:1]));
        end
      end
    end
  end

  // driver
  int pending[N];
  int cool[N];
  int gap_lo = 0;
  int gap_hi = 0;
  bit rand_coords = 1'b0;
  bit scramble = 1'b0;

  task automatic step();
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      if (req[i] && ack[i]) begin
        req[i] = 1'b0;
        pending[i]--;
        cool[i] = $urandom_range(gap_hi, gap_lo);
      end else if (!req[i]) begin
        if (cool[i] > 0) cool[i]--;
        else if (pending[i] > 0) begin
          if (rand_coords) begin
            x_in[8*i +: 8] = 8'($urandom_range(35, 0));
            y_in[7*i +: 7] = 7'($urandom_range(30, 0));
          end
          req[i] = 1'b1;
        end
      end else if (scramble && gnt[i]) begin
        x_in[8*i +: 8] = 8'($urandom_range(255, 0));
        y_in[7*i +: 7] = 7'($urandom_range(127, 0));
      end
    end
  endtask

  task automatic wait_gnt(input int i);
    int t;
    t = 0;
    step();
    while (!gnt[i] && t < 30) begin
      step();
      t++;
    end
    check($sformatf("gnt%0d_wait", i), 32'(gnt[i]), 32'(1));
  endtask

  task automatic drain(input int budget);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < budget) begin
      step();
      t++;
      done = (req == '0);
      for (int i = 0; i < N; i++) if (pending[i] != 0) done = 1'b0;
    end
    check("drain_done", 32'(done), 32'(1));
    step();
    step();
  endtask

  initial begin
    logic bw;
    for (int i = 0; i < N; i++) begin
      pending[i] = 1;
      cool[i] = 0;
    end

    // reset with all requests held
    reset_n = 1'b0;
    req = '1;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_wall", 32'(wall_out), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_map_x", 32'(map_x), 32'(0));
    check("rst_map_y", 32'(map_y), 32'(0));
    reset_n = 1'b1;
    step();
    check("first_gnt", 32'(gnt), 32'(3'b001));
    drain(100);

    // round-robin fairness
    got_order.delete();
    gap_lo = 1;
    gap_hi = 1;
    rand_coords = 1'b1;
    for (int i = 0; i < N; i++) pending[i] = 2;
    drain(200);
    check("order_len", 32'(got_order.size()), 32'(6));
    for (int i = 0; i < 6 && i < got_order.size(); i++)
      check($sformatf("order_%0d", i), 32'(got_order[i]), 32'(i % 3));

    // single request on requester 1
    gap_lo = 0;
    gap_hi = 0;
    rand_coords = 1'b0;
    x_in[15:8] = 8'd5;
    y_in[13:7] = 7'd3;
    req[1] = 1'b1;
    pending[1] = 1;
    wait_gnt(1);
    check("single_map_x", 32'(map_x), 32'(5));
    check("single_map_y", 32'(map_y), 32'(3));
    step();
    check("single_ack", 32'(ack), 32'(3'b010));
    check("single_wall", 32'(wall_out), 32'(0));
    step();
    check("single_busy_low", 32'(busy), 32'(0));
    step();

    // coordinate latch
    x_in[7:0] = 8'd10;
    y_in[6:0] = 7'd4;
    req[0] = 1'b1;
    pending[0] = 1;
    wait_gnt(0);
    x_in[7:0] = 8'd20;
    step();
    check("latch_map_x", 32'(map_x), 32'(10));
    check("latch_ack", 32'(ack), 32'(3'b001));
    step();
    step();

    // bounds check at x = MAP_W
`ifdef MAP_ARB_BOUNDS_CHECK_EN
    bw = 1'b1;
`else
    bw = 1'b0;
`endif
    x_in[7:0] = 8'd27;
    y_in[6:0] = 7'd0;
    req[0] = 1'b1;
    pending[0] = 1;
    wait_gnt(0);
    step();
    check("bounds_wall", 32'(wall_out), 32'(bw));
    step();
    step();

    // reset during LOOKUP; grant restarts from the lowest active requester
    req[0] = 1'b1;
    req[1] = 1'b1;
    pending[0] = 1;
    pending[1] = 1;
    wait_gnt(1);
    reset_n = 1'b0;
    step();
    check("midrst_ack", 32'(ack), 32'(0));
    check("midrst_gnt", 32'(gnt), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    reset_n = 1'b1;
    step();
    check("midrst_next_gnt", 32'(gnt), 32'(3'b001));
    drain(100);

    // random traffic
    rand_coords = 1'b1;
    scramble = 1'b1;
    gap_lo = 0;
    gap_hi = 3;
    for (int i = 0; i < N; i++) pending[i] = $urandom_range(10, 5);
    drain(3000);

    step();
    step();
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
